// File: rtl/mc_ctrl_fsm_pkg.sv
// Multicycle controller: shared state, opcode, func and ALU codes.
// Decode helper for the R-type function field.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_R   = 4'd2,
    S_EXE_I   = 4'd3,
    S_EXE_BR  = 4'd4,
    S_EXE_J   = 4'd5,
    S_EXE_MEM = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_WB_R    = 4'd9,
    S_WB_I    = 4'd10,
    S_WB_LW   = 4'd11,
    S_TRAP    = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  localparam logic [2:0] SRCB_REGB = 3'b000;
  localparam logic [2:0] SRCB_SIMM = 3'b010;
  localparam logic [2:0] SRCB_BOFS = 3'b011;
  localparam logic [2:0] SRCB_FOUR = 3'b100;
  localparam logic [2:0] SRCB_ZIMM = 3'b101;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_OUT = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef struct packed {
    logic       ok;
    logic [3:0] alu;
  } fdec_t;

  function automatic fdec_t dec_func(input logic [5:0] f);
    fdec_t r;
    r.ok  = 1'b1;
    r.alu = ALU_ADD;
    case (f)
      FN_ADD:  r.alu = ALU_ADD;
      FN_SUB:  r.alu = ALU_SUB;
      FN_AND:  r.alu = ALU_AND;
      FN_OR:   r.alu = ALU_OR;
      FN_XOR:  r.alu = ALU_XOR;
      FN_NOR:  r.alu = ALU_NOR;
      FN_SLT:  r.alu = ALU_SLT;
      FN_SLL:  r.alu = ALU_SLL;
      FN_SRL:  r.alu = ALU_SRL;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_wait_ctr.sv
// Memory wait counter with timeout compare.
// Timeout fires on the cycle that would bring the count to TIMEOUT.
module mc_wait_ctr
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tmo_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tmo_o = inc_i && (cnt_q == LAST);

  // Clear on entry/exit or timeout, count stalled cycles otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tmo_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle datapath controller FSM.
// IF, MEM_RD and MEM_WR stall on mem_ready with a bounded wait.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter bit          EN_TRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       AluSrcA,
  output logic       ALUOutWrite,
  output logic       IorD,
  output logic       PCWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [2:0] AluSrcB,
  output logic [3:0] ALUop,
  output logic [1:0] PCSrc,
  output logic       trap,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;
  state_e bad_d;
  fdec_t  fd;
  logic   wait_st;
  logic   inc;
  logic   clr;
  logic   tmo;
  logic   is_imm;
  logic   is_br;
  logic   is_mem;

  assign fd      = dec_func(func);
  assign bad_d   = EN_TRAP ? S_TRAP : S_IF;
  assign is_imm  = (op == OP_ADDI) || (op == OP_ANDI) ||
                   (op == OP_ORI)  || (op == OP_SLTI);
  assign is_br   = (op == OP_BEQ) || (op == OP_BNE);
  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign wait_st = (state_q == S_IF) || (state_q == S_MEM_RD) ||
                   (state_q == S_MEM_WR);
  assign inc     = wait_st && !mem_ready;
  assign clr     = !wait_st || (state_d != state_q);
  assign state   = state_q;

  mc_wait_ctr #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (inc),
    .tmo_o (tmo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IF, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          unique case (state_q)
            S_IF:     state_d = S_ID;
            S_MEM_RD: state_d = S_WB_LW;
            default:  state_d = S_IF;
          endcase
        end else if (tmo) begin
          state_d = EN_TRAP ? S_TRAP : state_q;
        end
      end
      S_ID: begin
        unique case (1'b1)
          (op == OP_R): state_d = S_EXE_R;
          is_imm:       state_d = S_EXE_I;
          is_br:        state_d = S_EXE_BR;
          (op == OP_J): state_d = S_EXE_J;
          is_mem:       state_d = S_EXE_MEM;
          default:      state_d = bad_d;
        endcase
      end
      S_EXE_R:   state_d = fd.ok ? S_WB_R : bad_d;
      S_EXE_I:   state_d = S_WB_I;
      S_EXE_MEM: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_EXE_BR,
      S_EXE_J,
      S_WB_R,
      S_WB_I,
      S_WB_LW:   state_d = S_IF;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_IF;
    endcase
  end

  // Per-state datapath strobes and selects
  always_comb begin
    IRWrite     = 1'b0;
    MDRWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ABWrite     = 1'b0;
    AluSrcA     = 1'b0;
    ALUOutWrite = 1'b0;
    IorD        = 1'b0;
    PCWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    AluSrcB     = SRCB_REGB;
    ALUop       = ALU_ADD;
    PCSrc       = PC_ALU;
    trap        = 1'b0;
    unique case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        AluSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_ID: begin
        ABWrite     = 1'b1;
        ALUOutWrite = 1'b1;
        AluSrcB     = SRCB_BOFS;
      end
      S_EXE_R: begin
        AluSrcA     = 1'b1;
        ALUOutWrite = fd.ok;
        ALUop       = fd.alu;
      end
      S_EXE_I: begin
        AluSrcA     = 1'b1;
        ALUOutWrite = 1'b1;
        unique case (1'b1)
          (op == OP_SLTI): begin
            AluSrcB = SRCB_SIMM;
            ALUop   = ALU_SLT;
          end
          (op == OP_ANDI): begin
            AluSrcB = SRCB_ZIMM;
            ALUop   = ALU_AND;
          end
          (op == OP_ORI): begin
            AluSrcB = SRCB_ZIMM;
            ALUop   = ALU_OR;
          end
          default: AluSrcB = SRCB_SIMM;
        endcase
      end
      S_EXE_BR: begin
        AluSrcA = 1'b1;
        ALUop   = ALU_SUB;
        PCSrc   = PC_OUT;
        PCWrite = (op == OP_BNE) ? ~zero : zero;
      end
      S_EXE_J: begin
        PCSrc   = PC_JMP;
        PCWrite = 1'b1;
      end
      S_EXE_MEM: begin
        AluSrcA     = 1'b1;
        AluSrcB     = SRCB_SIMM;
        ALUOutWrite = 1'b1;
      end
      S_MEM_RD: begin
        IorD     = 1'b1;
        MemRead  = 1'b1;
        MDRWrite = mem_ready;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_WB_I:  RegWrite = 1'b1;
      S_WB_LW: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: one trapping and one non-trapping instance.
// Expectations queued per cycle, compared on the falling edge.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;

  logic       irw, mdrw, rdst, m2r, rw, abw, srca, aow;
  logic       iord, pcw, mrd, mwr, trp;
  logic [2:0] srcb;
  logic [3:0] aluop, st;
  logic [1:0] pcsrc;

  logic       irw_n, mdrw_n, rdst_n, m2r_n, rw_n, abw_n, srca_n, aow_n;
  logic       iord_n, pcw_n, mrd_n, mwr_n, trp_n;
  logic [2:0] srcb_n;
  logic [3:0] aluop_n, st_n;
  logic [1:0] pcsrc_n;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(8), .EN_TRAP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready),
    .IRWrite(irw), .MDRWrite(mdrw), .RegDst(rdst), .MemtoReg(m2r),
    .RegWrite(rw), .ABWrite(abw), .AluSrcA(srca), .ALUOutWrite(aow),
    .IorD(iord), .PCWrite(pcw), .MemRead(mrd), .MemWrite(mwr),
    .AluSrcB(srcb), .ALUop(aluop), .PCSrc(pcsrc), .trap(trp),
    .state(st)
  );

  mc_ctrl_fsm #(.MEM_TIMEOUT(8), .EN_TRAP(1'b0)) u_dut_nt (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready),
    .IRWrite(irw_n), .MDRWrite(mdrw_n), .RegDst(rdst_n),
    .MemtoReg(m2r_n), .RegWrite(rw_n), .ABWrite(abw_n),
    .AluSrcA(srca_n), .ALUOutWrite(aow_n), .IorD(iord_n),
    .PCWrite(pcw_n), .MemRead(mrd_n), .MemWrite(mwr_n),
    .AluSrcB(srcb_n), .ALUop(aluop_n), .PCSrc(pcsrc_n), .trap(trp_n),
    .state(st_n)
  );

  localparam int O_ST = 0, O_TRAP = 1, O_RW = 2, O_MDR = 3;
  localparam int O_PCW = 4, O_PCSRC = 5, O_MWR = 6, O_MRD = 7;
  localparam int O_IRW = 8, O_SRCB = 9, O_ALU = 10, O_RDST = 11;
  localparam int O_M2R = 12, O_BOTH = 13, O_IORD = 14;
  localparam int N_ST = 20, N_RW = 21, N_PCW = 22, N_MWR = 23;
  localparam int N_TRAP = 24;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_run  = 0;
  int   n_fail = 0;

  logic [5:0] fl[6] = '{6'h22, 6'h24, 6'h27, 6'h2A, 6'h00, 6'h02};
  logic [3:0] al[6] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8};

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      O_ST:    obs = {4'd0, st};
      O_TRAP:  obs = {7'd0, trp};
      O_RW:    obs = {7'd0, rw};
      O_MDR:   obs = {7'd0, mdrw};
      O_PCW:   obs = {7'd0, pcw};
      O_PCSRC: obs = {6'd0, pcsrc};
      O_MWR:   obs = {7'd0, mwr};
      O_MRD:   obs = {7'd0, mrd};
      O_IRW:   obs = {7'd0, irw};
      O_SRCB:  obs = {5'd0, srcb};
      O_ALU:   obs = {4'd0, aluop};
      O_RDST:  obs = {7'd0, rdst};
      O_M2R:   obs = {7'd0, m2r};
      O_BOTH:  obs = {7'd0, mrd & mwr};
      O_IORD:  obs = {7'd0, iord};
      N_ST:    obs = {4'd0, st_n};
      N_RW:    obs = {7'd0, rw_n};
      N_PCW:   obs = {7'd0, pcw_n};
      N_MWR:   obs = {7'd0, mwr_n};
      N_TRAP:  obs = {7'd0, trp_n};
      default: obs = 8'hEE;
    endcase
  endfunction

  task automatic want(input int sel, input logic [7:0] v,
                      input string tag);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic set(input logic r, input logic [5:0] o,
                     input logic [5:0] f, input logic z);
    mem_ready = r;
    op        = o;
    func      = f;
    zero      = z;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic fetch_dec(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input string tag);
    set(1'b1, o, f, z);
    want(O_ST, 8'd0, {tag, "_if"});
    nxt();
    want(O_ST, 8'd1, {tag, "_id"});
    nxt();
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      check(cur.tag, obs(cur.sel), cur.val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog run=%0d", n_run);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set(1'b0, 6'h00, 6'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    want(O_ST, 8'd0, "rst_st");
    want(O_TRAP, 8'd0, "rst_trap");
    want(O_IRW, 8'd0, "rst_irw");
    want(O_PCW, 8'd0, "rst_pcw");
    want(O_MRD, 8'd1, "rst_mrd");
    want(O_SRCB, 8'd4, "rst_srcb");
    nxt();

    set(1'b1, 6'h00, 6'h20, 1'b0);
    want(O_IRW, 8'd1, "add_irw");
    want(O_PCW, 8'd1, "add_pcw");
    fetch_dec(6'h00, 6'h20, 1'b0, "add");
    want(O_ST, 8'd2, "add_exe");
    want(O_ALU, 8'd0, "add_alu");
    want(O_RW, 8'd0, "add_rw_exe");
    nxt();
    want(O_ST, 8'd9, "add_wb");
    want(O_RW, 8'd1, "add_rw_wb");
    want(O_RDST, 8'd1, "add_rdst");
    nxt();

    for (int i = 0; i < 6; i++) begin
      fetch_dec(6'h00, fl[i], 1'b0, "rfn");
      want(O_ALU, {4'd0, al[i]}, $sformatf("rfn_alu_%0h", fl[i]));
      nxt();
      want(O_RW, 8'd1, "rfn_wb");
      nxt();
    end

    fetch_dec(6'h23, 6'h00, 1'b0, "lw");
    want(O_ST, 8'd6, "lw_exm");
    want(O_SRCB, 8'd2, "lw_srcb");
    nxt();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      want(O_ST, 8'd7, "lw_wait_st");
      want(O_MDR, 8'd0, "lw_wait_mdr");
      want(O_IORD, 8'd1, "lw_iord");
      nxt();
    end
    mem_ready = 1'b1;
    want(O_ST, 8'd7, "lw_rdy_st");
    want(O_MDR, 8'd1, "lw_rdy_mdr");
    nxt();
    want(O_ST, 8'd11, "lw_wb");
    want(O_RW, 8'd1, "lw_rw");
    want(O_M2R, 8'd1, "lw_m2r");
    want(O_MDR, 8'd0, "lw_mdr_off");
    nxt();

    fetch_dec(6'h0C, 6'h00, 1'b0, "andi");
    want(O_ST, 8'd3, "andi_exe");
    want(O_SRCB, 8'd5, "andi_srcb");
    want(O_ALU, 8'd2, "andi_alu");
    nxt();
    want(O_ST, 8'd10, "andi_wb");
    want(O_RW, 8'd1, "andi_rw");
    nxt();

    fetch_dec(6'h0A, 6'h00, 1'b0, "slti");
    want(O_SRCB, 8'd2, "slti_srcb");
    want(O_ALU, 8'd6, "slti_alu");
    nxt();
    nxt();

    fetch_dec(6'h05, 6'h00, 1'b1, "bne1");
    want(O_ST, 8'd4, "bne1_st");
    want(O_PCW, 8'd0, "bne1_pcw");
    nxt();
    fetch_dec(6'h05, 6'h00, 1'b0, "bne0");
    want(O_PCW, 8'd1, "bne0_pcw");
    want(O_PCSRC, 8'd1, "bne0_pcsrc");
    want(O_ALU, 8'd1, "bne0_alu");
    nxt();
    fetch_dec(6'h04, 6'h00, 1'b1, "beq1");
    want(O_PCW, 8'd1, "beq1_pcw");
    nxt();
    fetch_dec(6'h04, 6'h00, 1'b0, "beq0");
    want(O_PCW, 8'd0, "beq0_pcw");
    nxt();

    fetch_dec(6'h02, 6'h00, 1'b0, "j");
    want(O_ST, 8'd5, "j_st");
    want(O_PCW, 8'd1, "j_pcw");
    want(O_PCSRC, 8'd2, "j_pcsrc");
    nxt();

    fetch_dec(6'h2B, 6'h00, 1'b0, "sw");
    want(O_ST, 8'd6, "sw_exm");
    nxt();
    want(O_ST, 8'd8, "sw_st");
    want(O_MWR, 8'd1, "sw_mwr");
    want(O_BOTH, 8'd0, "sw_rd_wr");
    nxt();
    want(O_ST, 8'd0, "sw_done");
    want(O_MWR, 8'd0, "sw_mwr_off");

    fetch_dec(6'h2B, 6'h00, 1'b0, "swr");
    nxt();
    mem_ready = 1'b0;
    want(O_ST, 8'd8, "swr_st");
    nxt();
    rst = 1'b1;
    want(O_MWR, 8'd1, "swr_mwr_in_rst");
    nxt();
    rst = 1'b0;
    want(O_ST, 8'd0, "swr_after_st");
    want(O_MWR, 8'd0, "swr_after_mwr");
    nxt();

    fetch_dec(6'h00, 6'h3F, 1'b0, "badfn");
    want(O_RW, 8'd0, "badfn_rw");
    nxt();
    mem_ready = 1'b0;
    want(O_ST, 8'd15, "badfn_trap_st");
    want(O_TRAP, 8'd1, "badfn_trap");
    want(N_ST, 8'd0, "badfn_nt_st");
    want(N_RW, 8'd0, "badfn_nt_rw");
    nxt();
    do_rst();

    fetch_dec(6'h3F, 6'h00, 1'b0, "badop");
    mem_ready = 1'b0;
    want(O_ST, 8'd15, "badop_st");
    want(O_TRAP, 8'd1, "badop_trap");
    want(O_MRD, 8'd0, "badop_mrd");
    want(N_ST, 8'd0, "badop_nt_st");
    want(N_TRAP, 8'd0, "badop_nt_trap");
    want(N_RW, 8'd0, "badop_nt_rw");
    want(N_PCW, 8'd0, "badop_nt_pcw");
    want(N_MWR, 8'd0, "badop_nt_mwr");
    nxt();
    set(1'b1, 6'h00, 6'h20, 1'b0);
    want(O_ST, 8'd15, "trap_hold");
    nxt();
    do_rst();

    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'b0;
      want(O_ST, 8'd0, $sformatf("tmo_wait_%0d", i));
      want(N_ST, 8'd0, $sformatf("tmo_nt_wait_%0d", i));
      nxt();
    end
    want(O_ST, 8'd15, "tmo_st");
    want(O_TRAP, 8'd1, "tmo_trap");
    want(N_ST, 8'd0, "tmo_nt_retry");
    want(N_TRAP, 8'd0, "tmo_nt_trap");
    nxt();
    rst = 1'b1;
    want(O_ST, 8'd15, "tmo_st_in_rst");
    nxt();
    rst = 1'b0;
    want(O_ST, 8'd0, "tmo_rst_st");
    want(O_TRAP, 8'd0, "tmo_rst_trap");

    @(negedge clk);
    #1;
    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
